// File: rtl/counter_pkg.sv
// Shared constants and constant functions for the parametrised counter family.
package counter_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Ceiling log2. Sizes the prescaler phase register; returns 0 for v <= 1.
  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Out-of-range load values saturate to the top of the count range.
  // Done at 64 bits so MODULUS = 2^32 cannot overflow.
  function automatic logic [63:0] clamp_load(input logic [63:0] val,
                                             input logic [63:0] modulus);
    return (val >= modulus) ? (modulus - 64'd1) : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
// clr restarts the phase so the next tick lands a full period later.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // No phase to track: every enabled cycle is a step.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clr};
      assign tick     = en;
    end else begin : g_count
      localparam int PW = clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] r_pc;
      logic          w_last;

      assign w_last = (r_pc == LAST);
      assign tick   = en && w_last;

      // Phase counter: frozen while en=0, wraps to 0 on the tick.
      always_ff @(posedge clk) begin
        if (rst || clr)  r_pc <= '0;
        else if (en)     r_pc <= w_last ? '0 : r_pc + PW'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// Generic up/down counter: modulus, prescaled enable, parallel load with
// clamping, wrap-or-saturate at the boundary, and one-cycle event pulses.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_evt,
  output logic             sat_evt
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (64'd1 << WIDTH) || PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_param
      $error("param_updown_counter: illegal WIDTH/MODULUS/PRESCALE");
    end
  endgenerate

  // Top of range at WIDTH bits; fits even when MODULUS = 2^WIDTH.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap_evt;
  logic             r_sat_evt;

  logic             w_tick;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_bound;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );

  assign w_at_top = (r_q == MAXV);
  assign w_at_bot = (r_q == '0);
  assign w_bound  = (mode == MODE_DOWN) ? w_at_bot : w_at_top;
  assign w_load_q = WIDTH'(clamp_load(64'(load_val), 64'(MODULUS)));

  // Next count and event for a step; with no tick the count holds and
  // both events drop, which also covers en=0.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_sat_nxt  = 1'b0;
    if (w_tick) begin
      if (w_bound && sat) begin
        w_sat_nxt = 1'b1;
      end else if (w_bound) begin
        w_wrap_nxt = 1'b1;
        w_q_nxt    = (mode == MODE_DOWN) ? MAXV : '0;
      end else begin
        w_q_nxt    = (mode == MODE_DOWN) ? r_q - WIDTH'(1) : r_q + WIDTH'(1);
      end
    end
  end

  // State update with priority rst > load > step/hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_wrap_evt <= 1'b0;
      r_sat_evt  <= 1'b0;
    end else if (load) begin
      r_q        <= w_load_q;
      r_wrap_evt <= 1'b0;
      r_sat_evt  <= 1'b0;
    end else begin
      r_q        <= w_q_nxt;
      r_wrap_evt <= w_wrap_nxt;
      r_sat_evt  <= w_sat_nxt;
    end
  end

  assign q        = r_q;
  assign wrap_evt = r_wrap_evt;
  assign sat_evt  = r_sat_evt;
  assign tc       = ((mode == MODE_UP) && w_at_top) || ((mode == MODE_DOWN) && w_at_bot);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three configurations share one stimulus
// stream; a behavioural model tracks all three, a vector table pins the
// 4-bit/mod-10 instance, and short sequences cover prescale and overflow.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, mode, sat, load;
  logic [3:0] lv4;
  logic [7:0] lv8;

  logic [3:0] qa, qb;
  logic [7:0] qc;
  logic       tca, tcb, tcc, wa, wb, wc, sa, sb, sc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .load(load),
    .load_val(lv4), .q(qa), .tc(tca), .wrap_evt(wa), .sat_evt(sa));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .load(load),
    .load_val(lv4), .q(qb), .tc(tcb), .wrap_evt(wb), .sat_evt(sb));

  param_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat), .load(load),
    .load_val(lv8), .q(qc), .tc(tcc), .wrap_evt(wc), .sat_evt(sc));

  // ---------------- reference model ----------------
  // Each instance: count value, enabled cycles since the last step,
  // and the events produced by the previous edge.
  int mq[3], mcyc[3];
  bit mw[3], ms[3];

  function automatic int modk(input int k);
    return (k == 2) ? 256 : 10;
  endfunction

  function automatic int prek(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int lv;
      lv = (k == 2) ? int'(lv8) : int'(lv4);
      mw[k] = 0;
      ms[k] = 0;
      if (rst) begin
        mq[k] = 0; mcyc[k] = 0;
      end else if (load) begin
        mq[k] = (lv > modk(k) - 1) ? modk(k) - 1 : lv;
        mcyc[k] = 0;
      end else if (en) begin
        mcyc[k] = mcyc[k] + 1;
        if (mcyc[k] == prek(k)) begin
          mcyc[k] = 0;
          if (!mode) begin
            if (mq[k] + 1 == modk(k)) begin
              if (sat) ms[k] = 1; else begin mq[k] = 0; mw[k] = 1; end
            end else mq[k] = mq[k] + 1;
          end else begin
            if (mq[k] == 0) begin
              if (sat) ms[k] = 1; else begin mq[k] = modk(k) - 1; mw[k] = 1; end
            end else mq[k] = mq[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] aq;
      logic       atc, aw, as;
      bit         etc;
      case (k)
        0:       begin aq = {4'h0, qa}; atc = tca; aw = wa; as = sa; end
        1:       begin aq = {4'h0, qb}; atc = tcb; aw = wb; as = sb; end
        default: begin aq = qc;         atc = tcc; aw = wc; as = sc; end
      endcase
      etc = mode ? (mq[k] == 0) : (mq[k] == modk(k) - 1);
      chk($sformatf("model dut%0d q", k),        64'(aq),  64'(mq[k]));
      chk($sformatf("model dut%0d tc", k),       64'(atc), 64'(etc));
      chk($sformatf("model dut%0d wrap_evt", k), 64'(aw),  64'(mw[k]));
      chk($sformatf("model dut%0d sat_evt", k),  64'(as),  64'(ms[k]));
    end
  endtask

  // One clock: apply inputs, take the edge, advance model, sample 1 ns later.
  task automatic cyc(input logic r, input logic e, input logic m, input logic s,
                     input logic l, input logic [3:0] v4, input logic [7:0] v8);
    rst = r; en = e; mode = m; sat = s; load = l; lv4 = v4; lv8 = v8;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // ---------------- vector table for dut_a (mod 10, prescale 1) ----------------
  typedef struct {
    logic       r, e, m, s, l;
    logic [3:0] v;
    int         q;
    logic       w, sa, tc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic m, input logic s,
                              input logic l, input logic [3:0] v,
                              input int q, input logic w, input logic sv, input logic tc);
    vec_t t;
    t.r = r; t.e = e; t.m = m; t.s = s; t.l = l; t.v = v;
    t.q = q; t.w = w; t.sa = sv; t.tc = tc;
    tbl.push_back(t);
  endfunction

  initial begin
    // reset state
    add(1,0,0,0,0,4'd0,  0,0,0,0);
    // count up 1..9, wrap to 0, then 1
    for (int i = 1; i <= 9; i++) add(0,1,0,0,0,4'd0, i,0,0,(i == 9));
    add(0,1,0,0,0,4'd0,  0,1,0,0);
    add(0,1,0,0,0,4'd0,  1,0,0,0);
    // load 0 in down mode, then count down 9..0 and wrap again
    add(0,1,1,0,1,4'd0,  0,0,0,1);
    add(0,1,1,0,0,4'd0,  9,1,0,0);
    for (int i = 8; i >= 0; i--) add(0,1,1,0,0,4'd0, i,0,0,(i == 0));
    add(0,1,1,0,0,4'd0,  9,1,0,0);
    // saturation at the top, then reverse direction
    add(0,1,0,1,1,4'd8,  8,0,0,0);
    add(0,1,0,1,0,4'd0,  9,0,0,1);
    add(0,1,0,1,0,4'd0,  9,0,1,1);
    add(0,1,0,1,0,4'd0,  9,0,1,1);
    add(0,1,1,1,0,4'd0,  8,0,0,0);
    // load clamp, load with en=0, hold, rst beats load
    add(0,1,0,0,1,4'hC,  9,0,0,1);
    add(0,0,0,0,1,4'd3,  3,0,0,0);
    add(0,0,0,0,0,4'd0,  3,0,0,0);
    add(1,1,0,0,1,4'd5,  0,0,0,0);
    // tc follows mode while frozen at 0; no step at boundary with en=0
    add(0,0,1,0,0,4'd0,  0,0,0,1);
    // wrap pulse ends when en drops
    add(0,1,0,0,1,4'd9,  9,0,0,1);
    add(0,1,0,0,0,4'd0,  0,1,0,0);
    add(0,0,0,0,0,4'd0,  0,0,0,0);
    // saturation at the bottom
    add(0,1,1,1,0,4'd0,  0,0,1,1);
  end

  // ---------------- test sequence ----------------
  initial begin
    bit m_r, s_r;
    rst = 1; en = 0; mode = 0; sat = 0; load = 0; lv4 = 0; lv8 = 0;
    #1;

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].l, tbl[i].v, {4'h0, tbl[i].v});
      chk($sformatf("tbl[%0d] q", i),        64'(qa),  64'(tbl[i].q));
      chk($sformatf("tbl[%0d] wrap_evt", i), 64'(wa),  64'(tbl[i].w));
      chk($sformatf("tbl[%0d] sat_evt", i),  64'(sa),  64'(tbl[i].sa));
      chk($sformatf("tbl[%0d] tc", i),       64'(tca), 64'(tbl[i].tc));
    end

    // Prescale 3: one step every third enabled cycle.
    cyc(1,0,0,0,0,4'd0,8'd0);   chk("pre rst q", 64'(qb), 0);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre c1 q", 64'(qb), 0);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre c2 q", 64'(qb), 0);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre c3 q", 64'(qb), 1);
    // en low for 2 cycles mid-phase delays the step by exactly 2 cycles
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre ph1 q", 64'(qb), 1);
    cyc(0,0,0,0,0,4'd0,8'd0);   chk("pre off1 q", 64'(qb), 1);
    cyc(0,0,0,0,0,4'd0,8'd0);   chk("pre off2 q", 64'(qb), 1);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre ph2 q", 64'(qb), 1);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre step2 q", 64'(qb), 2);
    // load mid-phase restarts the period
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre ph1b q", 64'(qb), 2);
    cyc(0,1,0,0,1,4'd5,8'd5);   chk("pre load q", 64'(qb), 5);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre ld1 q", 64'(qb), 5);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre ld2 q", 64'(qb), 5);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre ld3 q", 64'(qb), 6);
    // reset with q=6, phase=1: full period afterwards
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre q6 q", 64'(qb), 6);
    cyc(1,1,0,0,0,4'd0,8'd0);   chk("pre midrst q", 64'(qb), 0);
                                chk("pre midrst wrap", 64'(wb), 0);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre r1 q", 64'(qb), 0);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre r2 q", 64'(qb), 0);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("pre r3 q", 64'(qb), 1);

    // 8-bit, modulus 256: 255 -> 0 with no overflow, 255 loads unclamped.
    cyc(0,1,0,0,1,4'd0,8'd250); chk("ovf load q", 64'(qc), 250);
    for (int i = 251; i <= 255; i++) cyc(0,1,0,0,0,4'd0,8'd0);
    chk("ovf top q", 64'(qc), 255);
    chk("ovf top tc", 64'(tcc), 1);
    cyc(0,1,0,0,0,4'd0,8'd0);   chk("ovf wrap q", 64'(qc), 0);
                                chk("ovf wrap evt", 64'(wc), 1);
    cyc(0,1,0,1,1,4'd0,8'd255); chk("ovf load255 q", 64'(qc), 255);
    cyc(0,1,0,1,0,4'd0,8'd0);   chk("ovf sat q", 64'(qc), 255);
                                chk("ovf sat evt", 64'(sc), 1);

    // Random traffic against the model.
    m_r = 0; s_r = 0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 19) == 0) m_r = ~m_r;
      if ($urandom_range(0, 24) == 0) s_r = ~s_r;
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), m_r, s_r,
          ($urandom_range(0, 15) == 0), 4'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter, successor to the fixed 4-bit toggle-flop up/down counter. Adds configurable width, arbitrary modulus, a clock-enable prescaler, parallel load, and selectable wrap or saturate at the boundary. It provides terminal-count and wrap/saturate event outputs. Intended as the generic counting primitive for timers, address sequencers and the counter examples that follow.

Parameters:
WIDTH, 4, counter width in bits (1..32)
MODULUS, 16, count range 0..MODULUS-1; legal 2..2^WIDTH
PRESCALE, 1, enabled cycles per count step (1..2^16); 1 = step on every enabled cycle

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  count enable (the T input of the old counter); 0 = freeze q and prescaler
mode  input  1  0 = count up, 1 = count down
sat  input  1  0 = wrap at boundary, 1 = saturate (hold) at boundary
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load
q  output  WIDTH  current count
tc  output  1  terminal count (combinational)
wrap_evt  output  1  registered single-cycle pulse after a wrap step
sat_evt  output  1  registered single-cycle pulse after a step blocked by saturation

Behaviour:
- One clock only; reset is synchronous and active-high (port rst, sampled on rising clk edge). No asynchronous paths.
- Reset: q=0, prescaler count=0, wrap_evt=0, sat_evt=0.
- Per-edge priority: rst > load > step > hold.
- load=1: q <= min(load_val, MODULUS-1), i.e. out-of-range values clamp to MODULUS-1. Prescaler clears to 0; wrap_evt=0; sat_evt=0. load works regardless of en.
- Prescaler: internal counter pc, 0..PRESCALE-1. Advances only when en=1. tick = en && (pc == PRESCALE-1). pc wraps to 0 on tick. With PRESCALE=1, tick = en.
- Step on tick:
  - Up, q < MODULUS-1: q+1.
  - Up, q == MODULUS-1: if sat=0, q <= 0 and wrap_evt=1 next cycle; if sat=1, q holds and sat_evt=1.
  - Down, q > 0: q-1.
  - Down, q == 0: if sat=0, q <= MODULUS-1 and wrap_evt=1; if sat=1, q holds and sat_evt=1.
- Event pulses: wrap_evt and sat_evt are high for exactly the one cycle following the step, and low in every other cycle. They are never high together.
- tc = (mode==0 && q==MODULUS-1) || (mode==1 && q==0). It follows mode changes combinationally.
- en=0: q, pc and the events hold/deassert. No step, no event.
- mode or sat change mid-count: takes effect on the next tick. No extra step and no skipped value.
- Step latency: q updates on the clk edge where tick=1. An event is visible in the same cycle as the updated q.
- Arithmetic: compare against MODULUS-1 at WIDTH bits. No intermediate overflow is permitted, including when MODULUS = 2^WIDTH.
- Illegal parameters (MODULUS > 2^WIDTH, MODULUS < 2, PRESCALE < 1) are rejected at elaboration.

Decomposition:
- Shared package (counter_pkg):
  - MODE_UP=0 and MODE_DOWN=1 constants.
  - Function clog2 for sizing the prescaler width.
  - Function clamp_load(val, MODULUS).
- One sub-module: counter_prescaler (PRESCALE param; ports clk, rst, en, clr, tick). It is instanced with clr=load. When PRESCALE=1 it degenerates to tick=en.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1, sat=0, mode=0, en=1 after rst: q goes 0,1..9,0. wrap_evt is high only in the cycle q=0 after 9. tc is high while q=9.
- Same config, mode=1 from q=0: q goes 9,8..0,9. wrap_evt pulses once per wrap. tc is high at q=0.
- Saturation, sat=1: up from q=8 gives 9,9,9 with sat_evt high for each blocked step. Switching mode=1 then gives 8 on the next edge with sat_evt=0.
- Load and clamp: load=1 with load_val=4'hC gives q=9. Load with load_val=3 and en=0 gives q=3. Asserting load and rst on the same edge gives q=0.
- Prescaler, PRESCALE=3, en=1: q increments every 3rd cycle. Dropping en for 2 cycles mid-phase delays the next step by exactly 2 cycles. Load resets the phase (next step 3 enabled cycles after load).
- Reset mid-count (q=6, pc=1, then rst for 1 cycle): q=0, events=0, and counting resumes at full prescale period. Also run WIDTH=8, MODULUS=256 up through 255→0 to check there is no overflow.
